// File: rtl/arm_fetch_pkg.sv
// Shared types for the Thumb halfword fetch unit: FSM encoding, widths,
// the tagged halfword FIFO entry and a saturating counter helper.
package arm_fetch_pkg;

  localparam int HW_W    = 16;
  localparam int WORD_W  = 32;
  localparam int ENTRY_W = WORD_W + HW_W;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [HW_W-1:0]   data;
  } hw_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/hw_fifo.sv
// Halfword prefetch FIFO: push of one or two entries per cycle, single pop,
// flush. Head is presented straight from the storage registers.
module hw_fifo
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     push_two,
  input  logic [ENTRY_W-1:0]       push_a,
  input  logic [ENTRY_W-1:0]       push_b,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [AW:0]        push_n, pop_n;
  logic               pop_ok;

  assign empty  = (count_q == '0);
  assign free   = (AW+1)'(DEPTH) - count_q;
  assign head   = mem_q[rd_ptr_q];
  assign pop_ok = pop & ~empty;
  assign push_n = push ? (push_two ? (AW+1)'(2) : (AW+1)'(1)) : '0;
  assign pop_n  = {{AW{1'b0}}, pop_ok};

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_a;
        if (push_two) begin
          mem_d[wr_ptr_q + AW'(1)] = push_b;
        end
      end
      // Pointer arithmetic wraps naturally because DEPTH is a power of two.
      wr_ptr_d = wr_ptr_q + push_n[AW-1:0];
      rd_ptr_d = rd_ptr_q + pop_n[AW-1:0];
      count_d  = count_q + push_n - pop_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/thumb_hw_fetch.sv
// Fetches 32-bit instruction words and streams tagged Thumb halfwords to the core.
// Optional counters stat_words/stat_drops/stat_stall under THUMB_HW_FETCH_STATS_EN.
module thumb_hw_fetch
  import arm_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        hw_valid,
  output logic [15:0] hw_data,
  output logic [31:0] hw_pc,
  input  logic        hw_ready,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc
`ifdef THUMB_HW_FETCH_STATS_EN
  ,
  output logic [31:0] stat_words,
  output logic [31:0] stat_drops,
  output logic [31:0] stat_stall
`endif
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] TWO_FREE = (AW+1)'(2);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_ptr_q, fetch_ptr_d;
  logic         skip_lo_q, skip_lo_d;
  logic         stale_q, stale_d;

  logic [31:0]  word_addr;
  logic         rsp_take, word_accept, word_drop, pop;
  hw_entry_t    lo_entry, hi_entry, push_a, head_entry;
  logic         fifo_empty;
  logic [AW:0]  fifo_free;

  assign word_addr = fetch_ptr_q & 32'hFFFF_FFFC;
  assign mem_addr  = word_addr;
  assign mem_req   = (state_q == FETCH_REQ);

  // A response is usable only if nothing redirected the stream since its request.
  assign rsp_take    = (state_q == FETCH_WAIT) & mem_rvalid;
  assign word_accept = rsp_take & ~stale_q & ~redir_valid;
  assign word_drop   = rsp_take & ~word_accept;

  assign lo_entry = '{addr: word_addr,          data: mem_rdata[15:0]};
  assign hi_entry = '{addr: word_addr + 32'd2,  data: mem_rdata[31:16]};
  assign push_a   = skip_lo_q ? hi_entry : lo_entry;

  assign hw_valid = ~fifo_empty;
  assign hw_pc    = head_entry.addr;
  assign hw_data  = head_entry.data;
  assign pop      = hw_valid & hw_ready & ~redir_valid;

  hw_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redir_valid),
    .push     (word_accept),
    .push_two (~skip_lo_q),
    .push_a   (push_a),
    .push_b   (hi_entry),
    .pop      (pop),
    .head     (head_entry),
    .empty    (fifo_empty),
    .free     (fifo_free)
  );

  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    skip_lo_d   = skip_lo_q;
    stale_d     = stale_q;
    case (state_q)
      FETCH_IDLE: begin
        // Two free slots guarantee a full returning word always fits.
        if (!redir_valid && (fifo_free >= TWO_FREE)) begin
          state_d = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (mem_gnt) begin
          state_d = FETCH_WAIT;
          if (redir_valid) begin
            stale_d = 1'b1;
          end
        end else if (redir_valid) begin
          state_d = FETCH_IDLE;
        end
      end
      FETCH_WAIT: begin
        if (mem_rvalid) begin
          state_d = FETCH_IDLE;
          stale_d = 1'b0;
        end else if (redir_valid) begin
          stale_d = 1'b1;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
        stale_d = 1'b0;
      end
    endcase

    if (word_accept) begin
      fetch_ptr_d = word_addr + 32'd4;
      skip_lo_d   = 1'b0;
    end
    if (redir_valid) begin
      fetch_ptr_d = redir_pc & 32'hFFFF_FFFE;
      skip_lo_d   = redir_pc[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH_IDLE;
      fetch_ptr_q <= RESET_PC & 32'hFFFF_FFFE;
      skip_lo_q   <= RESET_PC[1];
      stale_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      skip_lo_q   <= skip_lo_d;
      stale_q     <= stale_d;
    end
  end

`ifdef THUMB_HW_FETCH_STATS_EN
  logic [31:0] stat_words_q, stat_words_d;
  logic [31:0] stat_drops_q, stat_drops_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_words_d = sat_inc(stat_words_q, word_accept);
    stat_drops_d = sat_inc(stat_drops_q, word_drop);
    stat_stall_d = sat_inc(stat_stall_q, hw_ready & ~hw_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_q <= '0;
      stat_drops_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_drops_q <= stat_drops_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_drops = stat_drops_q;
  assign stat_stall = stat_stall_q;
`else
  // Without statistics, word_drop has no consumer beyond this note of intent.
  logic unused_drop;
  assign unused_drop = word_drop;
`endif

endmodule

// File: tb/tb_thumb_hw_fetch.sv
// Self-checking bench for thumb_hw_fetch: memory responder, halfword scoreboard,
// table of redirect scenarios and hand-written stale/reset sequences.
module tb_thumb_hw_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        hw_valid;
  logic [15:0] hw_data;
  logic [31:0] hw_pc;
  logic        hw_ready;
  logic        redir_valid;
  logic [31:0] redir_pc;
`ifdef THUMB_HW_FETCH_STATS_EN
  logic [31:0] stat_words, stat_drops, stat_stall;
`endif

  always #5 clk = ~clk;

  thumb_hw_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .hw_valid    (hw_valid),
    .hw_data     (hw_data),
    .hw_pc       (hw_pc),
    .hw_ready    (hw_ready),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc)
`ifdef THUMB_HW_FETCH_STATS_EN
    ,
    .stat_words  (stat_words),
    .stat_drops  (stat_drops),
    .stat_stall  (stat_stall)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] redir;
    logic [31:0] gnt0;
    logic [31:0] gnt1;
    int          n_hw;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] gnt_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 1;
  bit          rand_gnt = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hBF00_2001;
    return {a[15:0] ^ 16'h5A5A, a[15:0] + 16'h1111};
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word(pc & 32'hFFFF_FFFC);
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] gnt_at(input int i);
    return (i < gnt_log.size()) ? gnt_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    pc = start & 32'hFFFF_FFFE;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc: pc, data: hw_at(pc)});
      pc = pc + 32'd2;
    end
  endtask

  // All tasks below are entered 1 time unit after a rising edge.
  task automatic drain(input string name, input int budget);
    int c;
    c = 0;
    hw_ready = 1'b1;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    hw_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d halfwords outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    hw_ready    = 1'b0;
    redir_valid = 1'b1;
    redir_pc    = pc;
    @(posedge clk); #1;
    redir_valid = 1'b0;
    chk("hw_valid_after_redir", {31'b0, hw_valid}, 32'd0);
    gnt_log.delete();
    exp_q.delete();
  endtask

  task automatic wait_gnt(input string name, input int budget);
    int c;
    c = 0;
    while (gnt_log.size() == 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    n_checks++;
    if (gnt_log.size() == 0) begin
      n_fail++;
      $display("FAIL %s_gnt_timeout: no grant in %0d cycles, required one", name, budget);
    end
  endtask

  // Memory responder: one outstanding read, rvalid lat cycles after the grant.
  initial begin : responder
    bit          pending;
    int          cnt;
    logic [31:0] paddr, gaddr;
    pending = 1'b0; cnt = 0; paddr = '0; gaddr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      if (mem_gnt) begin
        pending = 1'b1;
        cnt     = lat;
        paddr   = gaddr;
      end
      if (pending) begin
        cnt--;
        if (cnt <= 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(paddr);
          pending    = 1'b0;
        end
      end
      mem_gnt = mem_req && !pending && (!rand_gnt || $urandom_range(0, 2) != 0);
      gaddr   = mem_addr;
    end
  end

  // Monitor: compares each consumed halfword and logs granted addresses.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && hw_valid && hw_ready && !redir_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc=%h data=%h, required no halfword", hw_pc, hw_data);
        end else begin
          e = exp_q.pop_front();
          $display("hw pc=%h data=%h (want pc=%h data=%h)", hw_pc, hw_data, e.pc, e.data);
          chk("hw_pc", hw_pc, e.pc);
          chk("hw_data", {16'h0, hw_data}, {16'h0, e.data});
        end
      end
      if (mem_req && mem_gnt) begin
        gnt_log.push_back(mem_addr);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[5];
`ifdef THUMB_HW_FETCH_STATS_EN
    logic [31:0] drops0;
`endif
    vecs[0] = '{redir: 32'h0000_0106, gnt0: 32'h0000_0104, gnt1: 32'h0000_0108, n_hw: 3};
    vecs[1] = '{redir: 32'hFFFF_FFFC, gnt0: 32'hFFFF_FFFC, gnt1: 32'h0000_0000, n_hw: 4};
    vecs[2] = '{redir: 32'h0000_0200, gnt0: 32'h0000_0200, gnt1: 32'h0000_0204, n_hw: 4};
    vecs[3] = '{redir: 32'h0000_1003, gnt0: 32'h0000_1000, gnt1: 32'h0000_1004, n_hw: 3};
    vecs[4] = '{redir: 32'h0000_7FFE, gnt0: 32'h0000_7FFC, gnt1: 32'h0000_8000, n_hw: 2};

    rst_n = 1'b0; hw_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req",  {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_hw_valid", {31'b0, hw_valid}, 32'd0);
    chk("rst_hw_data",  {16'h0, hw_data}, 32'd0);
    chk("rst_hw_pc",    hw_pc, 32'h0);

    // Straight-line stream from reset with the core always ready.
    gnt_log.delete();
    push_stream(32'h0, 6);
    rst_n = 1'b1;
    drain("stream0", 200);
    chk("stream0_gnt0", gnt_at(0), 32'h0);
    chk("stream0_gnt1", gnt_at(1), 32'h4);

    // Core stalls: two words fill the FIFO, then fetching stops and the head holds.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    gnt_log.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i >= 4) begin
        chk("stall_hw_pc",   hw_pc, 32'h0);
        chk("stall_hw_data", {16'h0, hw_data}, 32'h0000_2001);
      end
    end
    chk("stall_gnt_count", gnt_log.size(), 32'd2);
    chk("stall_mem_req",   {31'b0, mem_req}, 32'd0);
    push_stream(32'h0, 4);
    drain("stall_release", 50);

    // Redirect table, with a memory that sometimes delays the grant.
    rand_gnt = 1'b1;
    foreach (vecs[v]) begin
      redirect(vecs[v].redir);
      push_stream(vecs[v].redir, vecs[v].n_hw);
      drain($sformatf("redir%0d", v), 300);
      chk($sformatf("redir%0d_gnt0", v), gnt_at(0), vecs[v].gnt0);
      chk($sformatf("redir%0d_gnt1", v), gnt_at(1), vecs[v].gnt1);
    end
    rand_gnt = 1'b0;

    // Redirect while waiting for 0x10: its data must be dropped.
    redirect(32'h0000_0010);
    lat = 3;
    wait_gnt("stale", 50);
    chk("stale_gnt_addr", gnt_at(0), 32'h10);
`ifdef THUMB_HW_FETCH_STATS_EN
    drops0 = stat_drops;
`endif
    redirect(32'h0000_0200);
    lat = 1;
    push_stream(32'h200, 4);
    drain("stale_redir", 200);
    chk("stale_new_gnt0", gnt_at(0), 32'h200);
`ifdef THUMB_HW_FETCH_STATS_EN
    chk("stat_drops_delta", stat_drops - drops0, 32'd1);
`endif

    // Reset in the middle of WAIT; the late response must be ignored.
    redirect(32'h0000_0040);
    lat = 6;
    wait_gnt("rst_wait", 50);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req",  {31'b0, mem_req}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_hw_valid", {31'b0, hw_valid}, 32'd0);
    chk("midrst_hw_data",  {16'h0, hw_data}, 32'd0);
    chk("midrst_hw_pc",    hw_pc, 32'h0);
`ifdef THUMB_HW_FETCH_STATS_EN
    chk("midrst_stat_drops", stat_drops, 32'd0);
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    lat = 1;
    gnt_log.delete();
    push_stream(32'h0, 4);
    rst_n = 1'b1;
    drain("after_rst", 200);
    chk("after_rst_gnt0", gnt_at(0), 32'h0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
